ring_phase_monitor: RTL and testbench

Downstream consumer of the N-bit one-hot ring counter. Each cycle it checks that the counter word is one-hot and has advanced exactly one position, encodes the active phase to a binary index, and locks after a configurable number of clean rotations. Once locked, it counts rotations and flags any sequencing fault. Its outputs feed phase-indexed logic (digit mux, TDM slot select) and the status/debug registers.

---
 rtl/ring_pkg.sv | 29 ++
 rtl/onehot_encoder.sv | 31 +++
 rtl/ring_phase_monitor.sv | 122 ++++++++++++
 tb/tb_ring_phase_monitor.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ring_pkg.sv
// Shared definitions for phase consumers of the one-hot ring counter.
//   state_e   : monitor FSM states
//   rotl1     : rotate-left-by-one of the low n bits of a vector
//   N_DEF     : default ring width
//   CNT_W_DEF : default width of the rotation/fault counters
package ring_pkg;

  localparam int N_DEF     = 4;
  localparam int CNT_W_DEF = 8;
  // Widest ring the rotl1 helper handles.
  localparam int MAX_N     = 64;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2,
    FAULT  = 2'd3
  } state_e;

  // Rotate the low n bits of v left by one; bits at and above n come out zero.
  function automatic logic [MAX_N-1:0] rotl1(input logic [MAX_N-1:0] v, input int n);
    logic [MAX_N-1:0] mask;
    logic [MAX_N-1:0] vm;
    mask  = {MAX_N{1'b1}} >> (MAX_N - n);
    vm    = v & mask;
    rotl1 = ((vm << 1) | (vm >> (n - 1))) & mask;
  endfunction

endpackage

// File: rtl/onehot_encoder.sv
// One-hot to binary encoder for ring phase words.
//   counter_i : N-bit ring word
//   idx_o     : index of the set bit, 0 when the word is not one-hot
//   onehot_o  : high when exactly one bit of counter_i is set
module onehot_encoder
  import ring_pkg::*;
#(
  parameter int  N     = N_DEF,
  localparam int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     counter_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             onehot_o
);

  logic [IDX_W-1:0] idx_raw;

  // Non-zero with no second bit set: clearing the lowest set bit leaves zero.
  assign onehot_o = (counter_i != '0) && ((counter_i & (counter_i - 1'b1)) == '0);

  // OR of indices of all set bits; only meaningful when the word is one-hot.
  always_comb begin
    idx_raw = '0;
    for (int i = 0; i < N; i++) begin
      if (counter_i[i]) idx_raw = idx_raw | IDX_W'(i);
    end
  end

  assign idx_o = onehot_o ? idx_raw : '0;

endmodule

// File: rtl/ring_phase_monitor.sv
// Ring phase monitor: checks each ring counter sample is one-hot and advanced
// by exactly one position, encodes the phase, locks after LOCK_ROT clean
// rotations, then counts rotations and flags sequencing faults.
//   clk, reset  : clock, synchronous active-high reset
//   counter     : ring counter word (N bits)
//   phase_idx   : binary index of the set bit of the last sample
//   phase_valid : last sample one-hot while tracking or locked
//   locked      : high while locked
//   err         : one-cycle pulse per fault seen while locked
//   rot_count   : rotations completed while locked (saturating)
//   err_count   : faults since reset (saturating)
module ring_phase_monitor
  import ring_pkg::*;
#(
  parameter int  N        = N_DEF,
  parameter int  LOCK_ROT = 2,
  parameter int  CNT_W    = CNT_W_DEF,
  localparam int IDX_W    = $clog2(N)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     counter,
  output logic [IDX_W-1:0] phase_idx,
  output logic             phase_valid,
  output logic             locked,
  output logic             err,
  output logic [CNT_W-1:0] rot_count,
  output logic [CNT_W-1:0] err_count
);

  localparam int               CLEAN_W = $clog2(LOCK_ROT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e             state_q;
  logic [N-1:0]       prev_q;
  logic [CLEAN_W-1:0] clean_q;

  logic               onehot;
  logic [IDX_W-1:0]   enc_idx;
  logic [N-1:0]       prev_rot;
  logic               step_ok;
  logic               rot_evt;
  logic [CLEAN_W-1:0] clean_inc;

  onehot_encoder #(.N(N)) u_enc (
    .counter_i (counter),
    .idx_o     (enc_idx),
    .onehot_o  (onehot)
  );

  // A held value fails this check because the expected word always moves.
  assign prev_rot  = N'(rotl1(MAX_N'(prev_q), N));
  assign step_ok   = onehot && (counter == prev_rot);
  assign rot_evt   = step_ok && counter[0];
  assign clean_inc = clean_q + CLEAN_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      prev_q      <= '0;
      clean_q     <= '0;
      phase_idx   <= '0;
      phase_valid <= 1'b0;
      locked      <= 1'b0;
      err         <= 1'b0;
      rot_count   <= '0;
      err_count   <= '0;
    end else begin
      prev_q      <= counter;
      phase_idx   <= enc_idx;
      // Status flags reflect the state being entered; branches raise them.
      phase_valid <= 1'b0;
      locked      <= 1'b0;
      err         <= 1'b0;
      case (state_q)
        IDLE: begin
          if (onehot) begin
            state_q     <= TRACK;
            clean_q     <= '0;
            phase_valid <= 1'b1;
          end
        end
        TRACK: begin
          if (!step_ok) begin
            state_q <= IDLE;
          end else begin
            phase_valid <= 1'b1;
            if (rot_evt) begin
              // The locking rotation itself is not counted in rot_count.
              if (clean_inc == CLEAN_W'(LOCK_ROT)) begin
                state_q <= LOCKED;
                clean_q <= '0;
                locked  <= 1'b1;
              end else begin
                clean_q <= clean_inc;
              end
            end
          end
        end
        LOCKED: begin
          if (step_ok) begin
            phase_valid <= 1'b1;
            locked      <= 1'b1;
            if (rot_evt && rot_count != CNT_MAX) rot_count <= rot_count + 1'b1;
          end else begin
            state_q <= FAULT;
            err     <= 1'b1;
            if (err_count != CNT_MAX) err_count <= err_count + 1'b1;
          end
        end
        FAULT: begin
          // Single-cycle recovery state; resume tracking from a usable sample.
          clean_q     <= '0;
          phase_valid <= onehot;
          state_q     <= onehot ? TRACK : IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ring_phase_monitor.sv
module tb_ring_phase_monitor;

  localparam int N    = 4;
  localparam int LOCK = 2;

  localparam int M_IDLE   = 0;
  localparam int M_TRACK  = 1;
  localparam int M_LOCKED = 2;
  localparam int M_FAULT  = 3;

  logic       clk;
  logic       reset;
  logic [3:0] counter;

  logic [1:0] idx8, idx2;
  logic       pv8, pv2, lk8, lk2, er8, er2;
  logic [7:0] rot8, errs8;
  logic [1:0] rot2, errs2;

  ring_phase_monitor #(.N(4), .LOCK_ROT(2), .CNT_W(8)) dut8 (
    .clk(clk), .reset(reset), .counter(counter),
    .phase_idx(idx8), .phase_valid(pv8), .locked(lk8), .err(er8),
    .rot_count(rot8), .err_count(errs8)
  );

  ring_phase_monitor #(.N(4), .LOCK_ROT(2), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .counter(counter),
    .phase_idx(idx2), .phase_valid(pv2), .locked(lk2), .err(er2),
    .rot_count(rot2), .err_count(errs2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int txn    = 0;

  typedef struct {
    logic [3:0] ctr;
    int idx; int pv; int lk; int er; int rot; int errs;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state (spec-level view of the monitor)
  int         m_mode  = M_IDLE;
  int         m_clean = 0;
  int         m_rot   = 0;
  int         m_errs  = 0;
  logic [3:0] m_prev  = 4'b0000;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_step(input logic [3:0] c, input bit rst);
    exp_t e;
    bit   oh, poh, stepok, wrap;
    int   idx, pidx, errp;
    errp = 0;
    if (rst) begin
      m_mode = M_IDLE; m_clean = 0; m_rot = 0; m_errs = 0; m_prev = 4'b0000;
      e = '{c, 0, 0, 0, 0, 0, 0};
    end else begin
      oh     = ($countones(c) == 1);
      poh    = ($countones(m_prev) == 1);
      idx    = oh  ? $clog2(c)      : 0;
      pidx   = poh ? $clog2(m_prev) : 0;
      stepok = oh && poh && (idx == (pidx + 1) % N);
      wrap   = stepok && (idx == 0);
      case (m_mode)
        M_IDLE: if (oh) begin m_mode = M_TRACK; m_clean = 0; end
        M_TRACK: begin
          if (!stepok) m_mode = M_IDLE;
          else if (wrap) begin
            m_clean++;
            if (m_clean == LOCK) begin m_mode = M_LOCKED; m_clean = 0; end
          end
        end
        M_LOCKED: begin
          if (stepok) begin
            if (wrap) m_rot++;
          end else begin
            m_mode = M_FAULT; errp = 1; m_errs++;
          end
        end
        default: begin m_mode = oh ? M_TRACK : M_IDLE; m_clean = 0; end
      endcase
      e.ctr  = c;
      e.idx  = idx;
      e.pv   = (oh && (m_mode == M_TRACK || m_mode == M_LOCKED)) ? 1 : 0;
      e.lk   = (m_mode == M_LOCKED) ? 1 : 0;
      e.er   = errp;
      e.rot  = m_rot;
      e.errs = m_errs;
      m_prev = c;
    end
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic [3:0] c, input bit rst);
    @(negedge clk);
    counter = c;
    reset   = rst;
    model_step(c, rst);
  endtask

  // Wait until the outputs for the last driven sample are settled.
  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  // Monitor: one expected entry per sampled edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        txn++;
        $display("txn %0d: ctr=%b idx=%0d pv=%0d lk=%0d err=%0d rot=%0d errs=%0d",
                 txn, e.ctr, idx8, pv8, lk8, er8, rot8, errs8);
        chk("idx8",  int'(idx8),  e.idx);
        chk("pv8",   int'(pv8),   e.pv);
        chk("lk8",   int'(lk8),   e.lk);
        chk("err8",  int'(er8),   e.er);
        chk("rot8",  int'(rot8),  sat(e.rot, 255));
        chk("errs8", int'(errs8), sat(e.errs, 255));
        chk("idx2",  int'(idx2),  e.idx);
        chk("pv2",   int'(pv2),   e.pv);
        chk("lk2",   int'(lk2),   e.lk);
        chk("err2",  int'(er2),   e.er);
        chk("rot2",  int'(rot2),  sat(e.rot, 3));
        chk("errs2", int'(errs2), sat(e.errs, 3));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] cur, nxt;
    int r;
    reset   = 1'b1;
    counter = 4'b0000;

    // Reset, then startup zeros
    drive(4'b0000, 1);
    drive(4'b0000, 1);
    settle();
    chk("reset_locked", int'(lk8), 0);
    chk("reset_rot", int'(rot8), 0);
    for (int i = 0; i < 5; i++) drive(4'b0000, 0);
    settle();
    chk("zeros_pv", int'(pv8), 0);

    // Clean run: 17 samples from 0001
    drive(4'b0000, 1);
    for (int i = 0; i < 17; i++) begin
      drive(4'(1 << (i % 4)), 0);
      if (i == 7) begin settle(); chk("clean_unlocked8", int'(lk8), 0); end
      if (i == 8) begin settle(); chk("clean_locked9", int'(lk8), 1); chk("clean_idx9", int'(idx8), 0); end
      if (i == 16) begin settle(); chk("clean_rot17", int'(rot8), 2); end
    end

    // Skip while locked
    drive(4'b0010, 0);
    drive(4'b1000, 0);
    settle();
    chk("skip_err", int'(er8), 1);
    chk("skip_errs", int'(errs8), 1);
    chk("skip_locked", int'(lk8), 0);
    for (int i = 0; i < 9; i++) drive(4'(1 << (i % 4)), 0);
    settle();
    chk("relock", int'(lk8), 1);

    // Non-one-hot while locked
    drive(4'b0110, 0);
    settle();
    chk("nonoh_err", int'(er8), 1);
    chk("nonoh_pv", int'(pv8), 0);
    chk("nonoh_idx", int'(idx8), 0);
    drive(4'b0001, 0);
    settle();
    chk("nonoh_track_pv", int'(pv8), 1);

    // Glitch in TRACK
    drive(4'b0000, 1);
    drive(4'b0001, 0);
    drive(4'b0010, 0);
    drive(4'b0010, 0);
    settle();
    chk("glitch_pv", int'(pv8), 0);
    chk("glitch_errs", int'(errs8), 0);

    // Saturation, then mid-run reset
    drive(4'b0000, 1);
    for (int i = 0; i < 29; i++) drive(4'(1 << (i % 4)), 0);
    settle();
    chk("sat_rot2", int'(rot2), 3);
    chk("sat_rot8", int'(rot8), 5);
    drive(4'b0010, 1);
    settle();
    chk("midreset_locked", int'(lk8), 0);
    chk("midreset_rot", int'(rot8), 0);

    // Randomized run
    cur = 4'b0001;
    for (int i = 0; i < 800; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 1) begin
        drive(cur, 1);
      end else begin
        if (r < 94)      nxt = ($countones(cur) == 1) ? {cur[2:0], cur[3]} : 4'b0001;
        else if (r < 96) nxt = cur;
        else if (r < 98) nxt = 4'($urandom_range(0, 15));
        else             nxt = {cur[1:0], cur[3:2]};
        drive(nxt, 0);
        cur = nxt;
      end
    end

    repeat (4) @(posedge clk);
    #2;
    chk("drain", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
